// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg
//   Shared types and default sizes for the data-memory arbiter.
//   grant_t      : who owns the RAM port in the current cycle.
//   last_grant_t : registered record of the previous cycle's grant; a forced
//                  host grant is kept distinct so it cannot repeat back to back.
//   cnt_width()  : bit width needed to hold 0..max_val.
package dm_arbiter_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_CORE = 2'd1,
        GRANT_HOST = 2'd2
    } grant_t;

    typedef enum logic [1:0] {
        LG_NONE        = 2'd0,
        LG_CORE        = 2'd1,
        LG_HOST_FREE   = 2'd2,
        LG_HOST_FORCED = 2'd3
    } last_grant_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if
//   Bundles the three ports that meet at the arbiter: the core data port,
//   the host request port and the RAM port.
//   slave  : the arbiter's view (takes requests, drives the RAM).
//   master : the environment's view (core, host and RAM model).
//
// Host handshake: a host transfer happens in a cycle where host_valid and
// host_ready are both 1. Once host_valid is raised, host_we/host_address/
// host_d stay stable and host_valid stays high until that cycle. host_ready
// is a same-cycle combinational answer and never depends on a future cycle.
// A read accepted in cycle N returns host_rdata with a one-cycle host_rvalid
// pulse in cycle N+1. The core side has no handshake: core_stall = 1 means
// the core's access this cycle did not happen and must be repeated.
interface dm_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_address;
    logic [DATA_W-1:0] core_d;
    logic [DATA_W-1:0] core_q;
    logic              core_stall;

    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_address;
    logic [DATA_W-1:0] host_d;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic              dm_we;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_d;
    logic [DATA_W-1:0] dm_q;

    modport slave (
        input  core_req, core_we, core_address, core_d,
        output core_q, core_stall,
        input  host_valid, host_we, host_address, host_d,
        output host_ready, host_rdata, host_rvalid,
        output dm_we, dm_address, dm_d,
        input  dm_q
    );

    modport master (
        output core_req, core_we, core_address, core_d,
        input  core_q, core_stall,
        output host_valid, host_we, host_address, host_d,
        input  host_ready, host_rdata, host_rvalid,
        input  dm_we, dm_address, dm_d,
        output dm_q
    );
endinterface

// File: rtl/dm_wait_counter.sv
// dm_wait_counter
//   Saturating up-counter measuring how long the host has been blocked.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : return to zero (wins over i_inc)
//   i_inc     : count up by one, holding at MAX_VAL
//   o_count   : current count
//   o_at_max  : count equals MAX_VAL
module dm_wait_counter
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_VAL = DEF_MAX_WAIT,
    parameter int CNT_W   = cnt_width(MAX_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] r_count;

    assign o_at_max = (r_count == MAX_CNT);
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares one single-port data RAM between the core data port and a host
//   port. The core normally wins; the host is forced in once it has been
//   blocked for MAX_WAIT cycles, stalling the core for that one cycle.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : core / host / RAM signals (dm_arbiter_if.slave)
//   o_grant      : this cycle's grant (debug)
//   o_last_grant : registered previous grant (debug)
//   o_wait_cnt   : host blocked-cycle counter (debug)
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = cnt_width(MAX_WAIT)
) (
    input  logic             clk,
    input  logic             rst,
    dm_arbiter_if.slave      bus,
    output grant_t           o_grant,
    output last_grant_t      o_last_grant,
    output logic [CNT_W-1:0] o_wait_cnt
);

    grant_t            w_grant;
    last_grant_t       r_last_grant;
    last_grant_t       w_last_next;
    logic              w_at_max;
    logic [CNT_W-1:0]  w_wait_cnt;
    logic              w_host_xfer;
    logic              w_dm_we;
    logic [ADDR_W-1:0] w_dm_address;
    logic [DATA_W-1:0] w_dm_d;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    dm_wait_counter #(
        .MAX_VAL (MAX_WAIT),
        .CNT_W   (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!bus.host_valid || w_host_xfer),
        .i_inc    (bus.host_valid && !w_host_xfer),
        .o_count  (w_wait_cnt),
        .o_at_max (w_at_max)
    );

    // Grant: the host takes the RAM freely when the core is idle, or by force
    // once it has waited MAX_WAIT cycles. A forced grant is never followed by
    // another forced grant, so the core stalls at most one cycle in a row.
    always_comb begin
        w_grant = GRANT_NONE;
        if (!rst) begin
            if (bus.host_valid &&
                (!bus.core_req || (w_at_max && r_last_grant != LG_HOST_FORCED))) begin
                w_grant = GRANT_HOST;
            end else if (bus.core_req) begin
                w_grant = GRANT_CORE;
            end
        end
    end

    // Next last_grant: a host grant is "forced" exactly when the core wanted
    // the RAM in the same cycle.
    always_comb begin
        w_last_next = LG_NONE;
        case (w_grant)
            GRANT_CORE: w_last_next = LG_CORE;
            GRANT_HOST: w_last_next = bus.core_req ? LG_HOST_FORCED : LG_HOST_FREE;
            default:    w_last_next = LG_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= LG_NONE;
        end else begin
            r_last_grant <= w_last_next;
        end
    end

    // RAM port mux and handshake outputs.
    always_comb begin
        w_dm_we        = 1'b0;
        w_dm_address   = '0;
        w_dm_d         = '0;
        bus.host_ready = 1'b0;
        bus.core_stall = 1'b0;
        case (w_grant)
            GRANT_CORE: begin
                w_dm_we      = bus.core_we;
                w_dm_address = bus.core_address;
                w_dm_d       = bus.core_d;
            end
            GRANT_HOST: begin
                w_dm_we        = bus.host_we;
                w_dm_address   = bus.host_address;
                w_dm_d         = bus.host_d;
                bus.host_ready = 1'b1;
                bus.core_stall = bus.core_req;
            end
            default: ;
        endcase
    end

    assign w_host_xfer    = (w_grant == GRANT_HOST);
    assign bus.dm_we      = w_dm_we;
    assign bus.dm_address = w_dm_address;
    assign bus.dm_d       = w_dm_d;
    assign bus.core_q     = bus.dm_q;

    // Host read return path. rvalid is masked by rst so a read accepted just
    // before reset never shows its pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_host_xfer && !bus.host_we;
            if (w_host_xfer && !bus.host_we) begin
                r_rdata <= bus.dm_q;
            end
        end
    end

    assign bus.host_rvalid = r_rvalid && !rst;
    assign bus.host_rdata  = r_rdata;

    assign o_grant      = w_grant;
    assign o_last_grant = r_last_grant;
    assign o_wait_cnt   = w_wait_cnt;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Bench for dm_arbiter: RAM model, directed scenarios and a randomized run,
//   all checked against a cycle-level reference model of the arbitration rules.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = cnt_width(MAX_WAIT);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grant_t           dut_grant;
    last_grant_t      dut_last;
    logic [CNT_W-1:0] dut_wait;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_grant      (dut_grant),
        .o_last_grant (dut_last),
        .o_wait_cnt   (dut_wait)
    );

    // RAM: combinational read, write on rising edge, cleared while in reset.
    logic [DATA_W-1:0] ram [0:255];
    assign bus.dm_q = ram[bus.dm_address[7:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (bus.dm_we) begin
            ram[bus.dm_address[7:0]] <= bus.dm_d;
        end
    end

    // ---------------- reference model state ----------------
    logic [DATA_W-1:0] m_mem [0:255];
    int                m_wait = 0;
    int                m_last = 0;   // 0 none, 1 core, 2 free host, 3 forced host
    bit                m_rv = 1'b0;
    bit                m_accept = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [DATA_W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic              obs_ready, obs_stall, obs_rvalid, obs_dm_we;
    logic [DATA_W-1:0] obs_rdata, obs_core_q;
    logic [ADDR_W-1:0] obs_dm_addr;
    int                obs_wait;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Who owns the RAM this cycle: 0 none, 1 core, 2 host.
    function automatic int exp_grant();
        if (rst) return 0;
        if (bus.host_valid && (!bus.core_req || (m_wait == MAX_WAIT && m_last != 3))) return 2;
        if (bus.core_req) return 1;
        return 0;
    endfunction

    task automatic check_outputs();
        int                g;
        logic              e_we, e_ready, e_stall, e_rv;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_d;
        g = exp_grant();
        e_we = 1'b0; e_a = '0; e_d = '0; e_ready = 1'b0; e_stall = 1'b0;
        if (g == 1) begin
            e_we = bus.core_we; e_a = bus.core_address; e_d = bus.core_d;
        end else if (g == 2) begin
            e_we = bus.host_we; e_a = bus.host_address; e_d = bus.host_d;
            e_ready = 1'b1; e_stall = bus.core_req;
        end
        e_rv = m_rv && !rst;
        check_eq("grant", 32'(dut_grant), 32'(g));
        check_eq("dm_we", 32'(bus.dm_we), 32'(e_we));
        check_eq("dm_address", 32'(bus.dm_address), 32'(e_a));
        check_eq("dm_d", bus.dm_d, e_d);
        check_eq("host_ready", 32'(bus.host_ready), 32'(e_ready));
        check_eq("core_stall", 32'(bus.core_stall), 32'(e_stall));
        check_eq("core_q", bus.core_q, m_mem[e_a[7:0]]);
        check_eq("host_rvalid", 32'(bus.host_rvalid), 32'(e_rv));
        check_eq("host_rdata", bus.host_rdata, m_rdata);
        check_eq("wait_cnt", 32'(dut_wait), 32'(m_wait));
        check_eq("last_grant", 32'(dut_last), 32'(m_last));
        if (e_rv && exp_q.size() > 0) check_eq("sb_rdata", bus.host_rdata, exp_q.pop_front());
        obs_ready = bus.host_ready; obs_stall = bus.core_stall; obs_rvalid = bus.host_rvalid;
        obs_dm_we = bus.dm_we; obs_rdata = bus.host_rdata; obs_core_q = bus.core_q;
        obs_dm_addr = bus.dm_address; obs_wait = int'(dut_wait);
    endtask

    task automatic model_update();
        int g;
        g = exp_grant();
        m_accept = (g == 2);
        if (rst) begin
            m_wait = 0; m_last = 0; m_rv = 1'b0; m_rdata = '0;
            exp_q.delete();
            for (int i = 0; i < 256; i++) m_mem[i] = '0;
        end else begin
            m_rv = (g == 2) && !bus.host_we;
            if (m_rv) begin
                m_rdata = m_mem[bus.host_address[7:0]];
                exp_q.push_back(m_rdata);
            end
            if (g == 1 && bus.core_we) m_mem[bus.core_address[7:0]] = bus.core_d;
            if (g == 2 && bus.host_we) m_mem[bus.host_address[7:0]] = bus.host_d;
            if (!bus.host_valid || g == 2) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            m_last = (g == 0) ? 0 : (g == 1) ? 1 : (bus.core_req ? 3 : 2);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are checked
    // on the falling edge; the model advances on the next rising edge.
    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_core(input bit req, input bit we, input int addr, input logic [31:0] d);
        bus.core_req = req; bus.core_we = we; bus.core_address = ADDR_W'(addr); bus.core_d = d;
    endtask

    task automatic drive_host(input bit valid, input bit we, input int addr, input logic [31:0] d);
        bus.host_valid = valid; bus.host_we = we; bus.host_address = ADDR_W'(addr); bus.host_d = d;
    endtask

    initial begin
        int first_ready, stall_at, n_stall, c10_ready, c10_stall, maxw, busy_xfers;
        bit done, h_pend;
        logic [ADDR_W-1:0] c10_addr;
        logic [DATA_W-1:0] retry_q;
        logic retry_stall;

        for (int i = 0; i < 256; i++) m_mem[i] = '0;

        // Reset with both requesters active: nothing may reach the RAM.
        drive_core(1, 1, 7, 32'h11); drive_host(1, 1, 3, 32'h22);
        rst = 1'b1;
        run_cycle(); run_cycle();
        rst = 1'b0;
        drive_core(0, 0, 0, 0); drive_host(0, 0, 0, 0);
        run_cycle();
        check_eq("rst_wait", 32'(obs_wait), 0);
        check_eq("rst_rvalid", 32'(obs_rvalid), 0);
        check_eq("rst_rdata", obs_rdata, 0);

        // Core store with idle host.
        drive_core(1, 1, 2, 32'h0000002A);
        run_cycle();
        check_eq("store_dm_we", 32'(obs_dm_we), 1);
        check_eq("store_no_stall", 32'(obs_stall), 0);
        drive_core(0, 0, 0, 0);
        run_cycle();
        check_eq("store_ram2", ram[2], 42);

        // Host write of -7 to addr 1, then host read of it.
        drive_host(1, 1, 1, 32'hFFFFFFF9);
        run_cycle();
        drive_host(1, 0, 1, 0);
        run_cycle();
        check_eq("hread_ready", 32'(obs_ready), 1);
        drive_host(0, 0, 0, 0);
        run_cycle();
        check_eq("hread_rvalid", 32'(obs_rvalid), 1);
        check_eq("hread_rdata", obs_rdata, 32'hFFFFFFF9);

        // Continuous core traffic: host forced in on cycle MAX_WAIT+1.
        drive_core(1, 0, 3, 0); drive_host(1, 0, 5, 0);
        first_ready = 0; stall_at = 0; n_stall = 0;
        c10_ready = 1; c10_stall = 1; c10_addr = '0;
        for (int c = 1; c <= 10; c++) begin
            run_cycle();
            if (obs_stall) n_stall++;
            if (obs_ready && first_ready == 0) begin
                first_ready = c; stall_at = int'(obs_stall);
            end
            if (c == 10) begin
                c10_ready = int'(obs_ready); c10_stall = int'(obs_stall); c10_addr = obs_dm_addr;
            end
        end
        check_eq("forced_cycle", 32'(first_ready), 9);
        check_eq("forced_stall", 32'(stall_at), 1);
        check_eq("forced_stall_count", 32'(n_stall), 1);
        check_eq("after_forced_ready", 32'(c10_ready), 0);
        check_eq("after_forced_stall", 32'(c10_stall), 0);
        check_eq("after_forced_addr", 32'(c10_addr), 3);
        drive_host(0, 0, 0, 0);
        run_cycle();

        // Host write addr 0 = 6 contends with core load of addr 0.
        drive_core(1, 0, 0, 0); drive_host(1, 1, 0, 32'd6);
        done = 1'b0; stall_at = 0; retry_q = '0; retry_stall = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (!done) begin
                run_cycle();
                if (obs_ready) begin
                    done = 1'b1; stall_at = int'(obs_stall);
                    drive_host(0, 0, 0, 0);
                    run_cycle();
                    retry_q = obs_core_q; retry_stall = obs_stall;
                end
            end
        end
        check_eq("contend_accepted", 32'(done), 1);
        check_eq("contend_stall", 32'(stall_at), 1);
        check_eq("retry_no_stall", 32'(retry_stall), 0);
        check_eq("retry_load", retry_q, 6);

        // Reset right after a host read is accepted: no rvalid pulse.
        drive_core(0, 0, 0, 0); drive_host(1, 0, 1, 0);
        run_cycle();
        check_eq("rstmid_accept", 32'(obs_ready), 1);
        drive_host(0, 0, 0, 0);
        rst = 1'b1;
        run_cycle();
        check_eq("rstmid_rvalid", 32'(obs_rvalid), 0);
        rst = 1'b0;
        drive_core(1, 0, 4, 0); drive_host(1, 0, 2, 0);
        run_cycle();
        check_eq("post_rst_wait", 32'(obs_wait), 0);
        check_eq("post_rst_core_wins", 32'(obs_ready), 0);
        check_eq("post_rst_rvalid", 32'(obs_rvalid), 0);
        drive_core(0, 0, 0, 0);
        run_cycle();
        drive_host(0, 0, 0, 0);
        run_cycle();

        // Continuous host traffic with core toggling every cycle.
        drive_host(1, 0, $urandom_range(0, 15), 0);
        maxw = 0; busy_xfers = 0;
        for (int c = 0; c < 40; c++) begin
            drive_core(c % 2 == 0, 0, $urandom_range(0, 15), 0);
            run_cycle();
            if (obs_wait > maxw) maxw = obs_wait;
            if (obs_ready && bus.core_req) busy_xfers++;
            if (m_accept) drive_host(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom());
        end
        check_eq("toggle_wait_le1", 32'(maxw <= 1), 1);
        check_eq("toggle_busy_xfers", 32'(busy_xfers), 0);
        drive_host(0, 0, 0, 0); drive_core(0, 0, 0, 0);
        run_cycle();

        // Randomized traffic with occasional reset; host holds until accepted.
        h_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!h_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    drive_host(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom());
                    h_pend = 1'b1;
                end else begin
                    drive_host(0, 0, 0, 0);
                end
            end
            drive_core($urandom_range(0, 15) < ((n % 400 < 200) ? 12 : 15),
                       $urandom_range(0, 1), $urandom_range(0, 15), $urandom());
            run_cycle();
            if (m_accept) h_pend = 1'b0;
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
